// File: rtl/display_buffer_arbiter_if.sv
// Signal bundle between the display buffer arbiter and its surroundings:
// PIO exports, LED scan reader, display RAM port and status flags.
interface display_buffer_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 24
);
   logic [ADDR_W-1:0] pio_addr;
   logic [DATA_W-1:0] pio_data;
   logic [7:0]        pio_ctrl;
   logic              scan_req;
   logic [ADDR_W-1:0] scan_addr;
   logic              frame_start;
   logic              scan_ack;
   logic              scan_valid;
   logic [DATA_W-1:0] scan_data;
   logic [ADDR_W:0]   ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              front_bank;
   logic              wr_pending;
   logic              swap_pending;
   logic              overflow;

   modport slave (
      input  pio_addr, pio_data, pio_ctrl, scan_req, scan_addr, frame_start, ram_rdata,
      output scan_ack, scan_valid, scan_data, ram_addr, ram_we, ram_wdata,
             front_bank, wr_pending, swap_pending, overflow
   );

   modport master (
      output pio_addr, pio_data, pio_ctrl, scan_req, scan_addr, frame_start, ram_rdata,
      input  scan_ack, scan_valid, scan_data, ram_addr, ram_we, ram_wdata,
             front_bank, wr_pending, swap_pending, overflow
   );
endinterface

// File: rtl/display_buffer_arbiter.sv
// Arbitrates one single-port double-banked display RAM between CPU PIO writes
// (back bank) and LED scan reads (front bank), with frame-aligned bank swaps.
module display_buffer_arbiter #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 24,
   parameter int MAX_WAIT = 8
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   display_buffer_arbiter_if.slave bus
);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic              primed_reg;
   logic [1:0]        prev_ctrl_reg;
   logic [1:0]        ctrl_evt;
   logic [ADDR_W-1:0] held_addr_reg;
   logic [DATA_W-1:0] held_data_reg;
   logic              wr_pending_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              swap_pending_reg;
   logic              front_bank_reg;
   logic              overflow_reg;
   logic [ADDR_W:0]   ram_addr_reg;
   logic              ram_we_reg;
   logic [DATA_W-1:0] ram_wdata_reg;
   logic              scan_ack_reg;
   logic              scan_valid_reg;

   logic write_evt;
   logic swap_evt;
   logic grant_wr;
   logic grant_rd;
   logic accept_wr;
   logic do_swap;

   // Each ctrl bit is a toggle: any edge on it is one event once primed.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_toggle
         assign ctrl_evt[gi] = primed_reg & (bus.pio_ctrl[gi] ^ prev_ctrl_reg[gi]);
      end
   endgenerate

   assign write_evt = ctrl_evt[0];
   assign swap_evt  = ctrl_evt[1];

   // A starved write wins outright once it has lost MAX_WAIT times.
   assign grant_wr  = wr_pending_reg & ((wait_cnt_reg == WAIT_W'(MAX_WAIT)) | ~bus.scan_req);
   assign grant_rd  = bus.scan_req & ~grant_wr;
   assign accept_wr = write_evt & (~wr_pending_reg | grant_wr);
   // Swap waits while a write is pending so it lands in the old back bank.
   assign do_swap   = bus.frame_start & swap_pending_reg & ~wr_pending_reg;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         primed_reg       <= 1'b0;
         prev_ctrl_reg    <= 2'b00;
         held_addr_reg    <= '0;
         held_data_reg    <= '0;
         wr_pending_reg   <= 1'b0;
         wait_cnt_reg     <= '0;
         swap_pending_reg <= 1'b0;
         front_bank_reg   <= 1'b0;
         overflow_reg     <= 1'b0;
         ram_addr_reg     <= '0;
         ram_we_reg       <= 1'b0;
         ram_wdata_reg    <= '0;
         scan_ack_reg     <= 1'b0;
         scan_valid_reg   <= 1'b0;
      end else begin
         primed_reg     <= 1'b1;
         prev_ctrl_reg  <= bus.pio_ctrl[1:0];
         ram_we_reg     <= 1'b0;
         scan_ack_reg   <= grant_rd;
         scan_valid_reg <= scan_ack_reg;

         if (grant_wr) begin
            ram_we_reg    <= 1'b1;
            ram_addr_reg  <= {~front_bank_reg, held_addr_reg};
            ram_wdata_reg <= held_data_reg;
            wait_cnt_reg  <= '0;
         end else if (grant_rd) begin
            ram_addr_reg  <= {front_bank_reg, bus.scan_addr};
         end

         if (wr_pending_reg && !grant_wr) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         end

         if (accept_wr) begin
            held_addr_reg  <= bus.pio_addr;
            held_data_reg  <= bus.pio_data;
            wr_pending_reg <= 1'b1;
         end else if (grant_wr) begin
            wr_pending_reg <= 1'b0;
         end

         if (write_evt && !accept_wr) begin
            overflow_reg <= 1'b1;
         end

         // A swap event arriving on the executing frame is absorbed.
         if (do_swap) begin
            front_bank_reg   <= ~front_bank_reg;
            swap_pending_reg <= 1'b0;
         end else if (swap_evt) begin
            swap_pending_reg <= 1'b1;
         end
      end
   end

   assign bus.ram_addr     = ram_addr_reg;
   assign bus.ram_we       = ram_we_reg;
   assign bus.ram_wdata    = ram_wdata_reg;
   assign bus.scan_ack     = scan_ack_reg;
   assign bus.scan_valid   = scan_valid_reg;
   // RAM output is only meaningful in the data cycle of a granted read.
   assign bus.scan_data    = scan_valid_reg ? bus.ram_rdata : '0;
   assign bus.front_bank   = front_bank_reg;
   assign bus.wr_pending   = wr_pending_reg;
   assign bus.swap_pending = swap_pending_reg;
   assign bus.overflow     = overflow_reg;
endmodule

// File: tb/tb_display_buffer_arbiter.sv
// Directed and randomized bench for display_buffer_arbiter, checked against a
// transaction-level model with a shadow copy of both RAM banks.
`timescale 1ns/1ps
module tb_display_buffer_arbiter;
   localparam int AW    = 11;
   localparam int DW    = 24;
   localparam int MW    = 8;
   localparam int DEPTH = 1 << (AW + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   display_buffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   display_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .bus          (bus_if)
   );

   function automatic logic [DW-1:0] init_word(int a);
      if (a == 'h010) return 24'h123456;
      if (a == 'h810) return 24'hABCDEF;
      return DW'(a * 40503 + 7);
   endfunction

   // Display RAM: registered read, write-before-nothing (old data on collision).
   logic [DW-1:0] mem [DEPTH];
   bit            mem_ready;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (bus_if.ram_we) begin
         mem[bus_if.ram_addr] <= bus_if.ram_wdata;
      end
      bus_if.ram_rdata <= mem[bus_if.ram_addr];
   end

   // Reference model state: what each output should read just after an edge.
   logic [DW-1:0] shadow [DEPTH];
   bit            m_primed, m_wr_pend, m_swap_pend, m_front, m_ovf, m_ack, m_valid, m_we;
   logic [1:0]    m_prev;
   logic [AW-1:0] m_haddr;
   logic [DW-1:0] m_hdata, m_data, m_rd_data, m_wdata;
   logic [AW:0]   m_addr;
   int            m_losses;

   task automatic model_reset();
      m_primed = 0; m_wr_pend = 0; m_swap_pend = 0; m_front = 0; m_ovf = 0;
      m_ack = 0; m_valid = 0; m_we = 0; m_prev = '0; m_haddr = '0; m_hdata = '0;
      m_data = '0; m_rd_data = '0; m_wdata = '0; m_addr = '0; m_losses = 0;
   endtask

   // Advance the model across one clock edge using the inputs now applied.
   task automatic model_step();
      bit wev, sev, want_w, take_w, take_r, swap_now;
      wev = m_primed && (bus_if.pio_ctrl[0] != m_prev[0]);
      sev = m_primed && (bus_if.pio_ctrl[1] != m_prev[1]);
      m_prev   = bus_if.pio_ctrl[1:0];
      m_primed = 1;
      swap_now = bus_if.frame_start && m_swap_pend && !m_wr_pend;
      m_valid  = m_ack;
      m_data   = m_ack ? m_rd_data : '0;
      m_ack    = 0;
      m_we     = 0;
      want_w   = m_wr_pend;
      take_w   = want_w && (m_losses >= MW || !bus_if.scan_req);
      take_r   = bus_if.scan_req && !take_w;
      if (take_w) begin
         m_we = 1;
         m_addr = {~m_front, m_haddr};
         m_wdata = m_hdata;
         shadow[m_addr] = m_hdata;
         m_wr_pend = 0;
         m_losses = 0;
      end else if (want_w) begin
         m_losses++;
      end
      if (take_r) begin
         m_ack = 1;
         m_addr = {m_front, bus_if.scan_addr};
         m_rd_data = shadow[m_addr];
      end
      if (wev) begin
         if (!m_wr_pend) begin
            m_haddr = bus_if.pio_addr;
            m_hdata = bus_if.pio_data;
            m_wr_pend = 1;
         end else begin
            m_ovf = 1;
         end
      end
      if (sev) m_swap_pend = 1;
      if (swap_now) begin
         m_front = ~m_front;
         m_swap_pend = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus_if.pio_ctrl = 8'h03;
      do_reset();
      rst_n = 1'b0;
      #2;
      total++;
      if ({bus_if.ram_we, bus_if.ram_addr, bus_if.scan_data, bus_if.front_bank,
           bus_if.scan_ack, bus_if.scan_valid, bus_if.overflow} !== '0) begin
         bad++;
         $display("FAIL reset_outputs we=%0b addr=%h data=%h front=%0b ack=%0b valid=%0b ovf=%0b want all 0",
                  bus_if.ram_we, bus_if.ram_addr, bus_if.scan_data, bus_if.front_bank,
                  bus_if.scan_ack, bus_if.scan_valid, bus_if.overflow);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({bus_if.wr_pending, bus_if.swap_pending, bus_if.front_bank, bus_if.ram_we} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_prime cyc=%0d wrp=%0b swp=%0b front=%0b we=%0b want 0000",
                     cyc, bus_if.wr_pending, bus_if.swap_pending, bus_if.front_bank, bus_if.ram_we);
         end
      end
   endtask

   task automatic test_single_write();
      bus_if.scan_req = 1'b0;
      bus_if.pio_addr = 11'h005;
      bus_if.pio_data = 24'hFF8000;
      bus_if.pio_ctrl = bus_if.pio_ctrl ^ 8'h01;
      tick();
      total++;
      if (bus_if.wr_pending !== 1'b1) begin
         bad++;
         $display("FAIL single_pending got=%0b want=1", bus_if.wr_pending);
      end
      tick();
      total++;
      if ({bus_if.ram_we, bus_if.ram_addr, bus_if.ram_wdata} !== {1'b1, 12'h805, 24'hFF8000}) begin
         bad++;
         $display("FAIL single_write we=%0b addr=%h wdata=%h want 1/805/ff8000",
                  bus_if.ram_we, bus_if.ram_addr, bus_if.ram_wdata);
      end
      tick();
      total++;
      if ({bus_if.ram_we, bus_if.wr_pending} !== 2'b00) begin
         bad++;
         $display("FAIL single_after we=%0b wrp=%0b want 0/0", bus_if.ram_we, bus_if.wr_pending);
      end
   endtask

   task automatic test_forced_write();
      int acks = 0, valids = 0, gaps = 0, we_at = 0, we_cnt = 0;
      logic [DW-1:0] wd;
      bus_if.scan_req  = 1'b1;
      bus_if.scan_addr = AW'($urandom);
      tick();
      if (bus_if.scan_ack) acks++;
      wd = DW'($urandom);
      bus_if.pio_addr = 11'h0AB;
      bus_if.pio_data = wd;
      bus_if.pio_ctrl = bus_if.pio_ctrl ^ 8'h01;
      for (int k = 1; k <= 22; k++) begin
         if (k == 21) bus_if.scan_req = 1'b0;
         tick();
         if (k <= 20) begin
            if (bus_if.scan_ack) acks++; else gaps++;
         end
         if (bus_if.scan_valid) begin
            valids++;
            total++;
            if (bus_if.scan_data !== m_data) begin
               bad++;
               $display("FAIL forced_rdata k=%0d got=%h want=%h", k, bus_if.scan_data, m_data);
            end
         end
         if (bus_if.ram_we) begin
            we_cnt++;
            we_at = k;
            total++;
            if ({bus_if.ram_addr, bus_if.ram_wdata} !== {12'h8AB, wd}) begin
               bad++;
               $display("FAIL forced_wr addr=%h wdata=%h want 8ab/%h", bus_if.ram_addr, bus_if.ram_wdata, wd);
            end
         end
      end
      total++;
      if (we_at !== 10 || we_cnt !== 1) begin
         bad++;
         $display("FAIL forced_timing we_at=%0d we_cnt=%0d want 10/1", we_at, we_cnt);
      end
      total++;
      if (gaps !== 1) begin
         bad++;
         $display("FAIL forced_gaps got=%0d want=1", gaps);
      end
      total++;
      if (valids !== acks) begin
         bad++;
         $display("FAIL forced_lost valids=%0d acks=%0d", valids, acks);
      end
   endtask

   task automatic test_back_to_back();
      bus_if.scan_req = 1'b1;
      for (int k = 0; k < 14; k++) begin
         bus_if.scan_addr = AW'($urandom);
         if (k >= 12) bus_if.scan_req = 1'b0;
         tick();
         total++;
         if ({bus_if.scan_ack, bus_if.scan_valid, bus_if.scan_data} !== {m_ack, m_valid, m_data}) begin
            bad++;
            $display("FAIL b2b k=%0d ack=%0b valid=%0b data=%h want %0b/%0b/%h",
                     k, bus_if.scan_ack, bus_if.scan_valid, bus_if.scan_data, m_ack, m_valid, m_data);
         end
         if (k >= 1 && k < 12) begin
            total++;
            if (bus_if.scan_ack !== 1'b1) begin
               bad++;
               $display("FAIL b2b_rate k=%0d ack=%0b want=1", k, bus_if.scan_ack);
            end
         end
      end
   endtask

   task automatic test_swap();
      bus_if.pio_ctrl = bus_if.pio_ctrl ^ 8'h02;
      tick();
      total++;
      if ({bus_if.swap_pending, bus_if.front_bank} !== 2'b10) begin
         bad++;
         $display("FAIL swap_pend swp=%0b front=%0b want 1/0", bus_if.swap_pending, bus_if.front_bank);
      end
      bus_if.frame_start = 1'b1;
      tick();
      bus_if.frame_start = 1'b0;
      total++;
      if ({bus_if.swap_pending, bus_if.front_bank} !== 2'b01) begin
         bad++;
         $display("FAIL swap_exec swp=%0b front=%0b want 0/1", bus_if.swap_pending, bus_if.front_bank);
      end
      // Write and swap together while the scanner keeps the write waiting.
      bus_if.scan_req = 1'b1;
      bus_if.pio_addr = 11'h033;
      bus_if.pio_data = 24'h5A5A5A;
      bus_if.pio_ctrl = bus_if.pio_ctrl ^ 8'h03;
      tick();
      bus_if.frame_start = 1'b1;
      tick();
      bus_if.frame_start = 1'b0;
      total++;
      if ({bus_if.front_bank, bus_if.swap_pending, bus_if.wr_pending} !== 3'b111) begin
         bad++;
         $display("FAIL swap_defer front=%0b swp=%0b wrp=%0b want 1/1/1",
                  bus_if.front_bank, bus_if.swap_pending, bus_if.wr_pending);
      end
      bus_if.scan_req = 1'b0;
      tick();
      total++;
      if ({bus_if.ram_we, bus_if.ram_addr, bus_if.ram_wdata} !== {1'b1, 12'h033, 24'h5A5A5A}) begin
         bad++;
         $display("FAIL swap_oldback we=%0b addr=%h wdata=%h want 1/033/5a5a5a",
                  bus_if.ram_we, bus_if.ram_addr, bus_if.ram_wdata);
      end
      bus_if.frame_start = 1'b1;
      tick();
      bus_if.frame_start = 1'b0;
      total++;
      if ({bus_if.front_bank, bus_if.swap_pending} !== 2'b00) begin
         bad++;
         $display("FAIL swap_late front=%0b swp=%0b want 0/0", bus_if.front_bank, bus_if.swap_pending);
      end
   endtask

   task automatic test_read_swap();
      bus_if.pio_ctrl = bus_if.pio_ctrl ^ 8'h02;
      tick();
      bus_if.scan_req  = 1'b1;
      bus_if.scan_addr = 11'h010;
      tick();
      total++;
      if ({bus_if.scan_ack, bus_if.ram_we, bus_if.ram_addr} !== {1'b1, 1'b0, 12'h010}) begin
         bad++;
         $display("FAIL rdswap_ack ack=%0b we=%0b addr=%h want 1/0/010",
                  bus_if.scan_ack, bus_if.ram_we, bus_if.ram_addr);
      end
      bus_if.scan_req    = 1'b0;
      bus_if.frame_start = 1'b1;
      tick();
      bus_if.frame_start = 1'b0;
      total++;
      if ({bus_if.scan_valid, bus_if.scan_data, bus_if.front_bank} !== {1'b1, 24'h123456, 1'b1}) begin
         bad++;
         $display("FAIL rdswap_data valid=%0b data=%h front=%0b want 1/123456/1",
                  bus_if.scan_valid, bus_if.scan_data, bus_if.front_bank);
      end
      bus_if.scan_req = 1'b1;
      tick();
      bus_if.scan_req = 1'b0;
      tick();
      total++;
      if ({bus_if.scan_valid, bus_if.scan_data} !== {1'b1, 24'hABCDEF}) begin
         bad++;
         $display("FAIL rdswap_newfront valid=%0b data=%h want 1/abcdef", bus_if.scan_valid, bus_if.scan_data);
      end
   endtask

   task automatic test_overflow();
      int we_cnt = 0;
      logic [DW-1:0] d1, d2;
      logic [AW:0]   exp_addr;
      d1 = DW'($urandom);
      d2 = d1 ^ 24'h00FFFF;
      bus_if.scan_req  = 1'b1;
      bus_if.scan_addr = 11'h020;
      tick();
      bus_if.pio_addr = 11'h0C1;
      bus_if.pio_data = d1;
      bus_if.pio_ctrl = bus_if.pio_ctrl ^ 8'h01;
      tick();
      exp_addr = {~m_front, 11'h0C1};
      bus_if.pio_addr = 11'h0C2;
      bus_if.pio_data = d2;
      bus_if.pio_ctrl = bus_if.pio_ctrl ^ 8'h01;
      tick();
      total++;
      if ({bus_if.overflow, bus_if.wr_pending} !== 2'b11) begin
         bad++;
         $display("FAIL ovf_flag ovf=%0b wrp=%0b want 1/1", bus_if.overflow, bus_if.wr_pending);
      end
      for (int k = 0; k < 14; k++) begin
         if (k == 12) bus_if.scan_req = 1'b0;
         tick();
         if (bus_if.ram_we) begin
            we_cnt++;
            total++;
            if ({bus_if.ram_addr, bus_if.ram_wdata} !== {exp_addr, d1}) begin
               bad++;
               $display("FAIL ovf_data addr=%h wdata=%h want %h/%h", bus_if.ram_addr, bus_if.ram_wdata, exp_addr, d1);
            end
         end
      end
      total++;
      if (we_cnt !== 1 || bus_if.overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_count writes=%0d ovf=%0b want 1/1", we_cnt, bus_if.overflow);
      end
   endtask

   task automatic test_random();
      logic [7:0] c;
      for (int k = 0; k < 400; k++) begin
         c = bus_if.pio_ctrl;
         if ($urandom_range(0, 5) == 0) c[0] = ~c[0];
         if ($urandom_range(0, 9) == 0) c[1] = ~c[1];
         c[7:2] = 6'($urandom);
         bus_if.pio_ctrl    = c;
         bus_if.pio_addr    = AW'($urandom);
         bus_if.pio_data    = DW'($urandom);
         bus_if.scan_req    = ($urandom_range(0, 3) != 0);
         bus_if.scan_addr   = AW'($urandom);
         bus_if.frame_start = ($urandom_range(0, 7) == 0);
         tick();
         total++;
         if ({bus_if.scan_ack, bus_if.scan_valid, bus_if.scan_data, bus_if.ram_addr, bus_if.ram_we,
              bus_if.ram_wdata, bus_if.front_bank, bus_if.wr_pending, bus_if.swap_pending, bus_if.overflow}
             !== {m_ack, m_valid, m_data, m_addr, m_we, m_wdata, m_front, m_wr_pend, m_swap_pend, m_ovf}) begin
            bad++;
            $display("FAIL rnd cyc=%0d ack/val/data=%0b/%0b/%h addr/we/wd=%h/%0b/%h fb/wp/sp/ov=%0b%0b%0b%0b want %0b/%0b/%h %h/%0b/%h %0b%0b%0b%0b",
                     cyc, bus_if.scan_ack, bus_if.scan_valid, bus_if.scan_data, bus_if.ram_addr, bus_if.ram_we,
                     bus_if.ram_wdata, bus_if.front_bank, bus_if.wr_pending, bus_if.swap_pending, bus_if.overflow,
                     m_ack, m_valid, m_data, m_addr, m_we, m_wdata, m_front, m_wr_pend, m_swap_pend, m_ovf);
         end
      end
      bus_if.scan_req    = 1'b0;
      bus_if.frame_start = 1'b0;
   endtask

   task automatic test_mid_reset();
      repeat (3) tick();
      bus_if.scan_req  = 1'b1;
      bus_if.scan_addr = 11'h044;
      bus_if.pio_ctrl  = bus_if.pio_ctrl ^ 8'h01;
      tick();
      total++;
      if ({bus_if.scan_ack, bus_if.wr_pending} !== 2'b11) begin
         bad++;
         $display("FAIL midrst_pre ack=%0b wrp=%0b want 1/1", bus_if.scan_ack, bus_if.wr_pending);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({bus_if.scan_ack, bus_if.wr_pending, bus_if.overflow, bus_if.ram_addr, bus_if.front_bank} !== '0) begin
         bad++;
         $display("FAIL midrst_clear ack=%0b wrp=%0b ovf=%0b addr=%h front=%0b want all 0",
                  bus_if.scan_ack, bus_if.wr_pending, bus_if.overflow, bus_if.ram_addr, bus_if.front_bank);
      end
      @(posedge clk);
      #1;
      total++;
      if ({bus_if.scan_valid, bus_if.scan_data} !== '0) begin
         bad++;
         $display("FAIL midrst_inflight valid=%0b data=%h want 0/0", bus_if.scan_valid, bus_if.scan_data);
      end
      rst_n = 1'b1;
      bus_if.scan_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if ({bus_if.ram_we, bus_if.wr_pending} !== {m_we, m_wr_pend} || bus_if.ram_we !== 1'b0) begin
            bad++;
            $display("FAIL midrst_nowrite k=%0d we=%0b wrp=%0b want 0/0", k, bus_if.ram_we, bus_if.wr_pending);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      bus_if.pio_addr    = '0;
      bus_if.pio_data    = '0;
      bus_if.pio_ctrl    = 8'h03;
      bus_if.scan_req    = 1'b0;
      bus_if.scan_addr   = '0;
      bus_if.frame_start = 1'b0;
      test_reset();
      test_single_write();
      test_forced_write();
      test_back_to_back();
      test_swap();
      test_read_swap();
      test_overflow();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/display_buffer_arbiter.md
Name: display_buffer_arbiter

Overview:
- Shares one single-port, double-banked display RAM between two requesters:
  - the CPU-side PIO write path (display_buffer addr/data/ctrl exports);
  - the LED scan-out reader.
- CPU writes always land in the back bank; scan reads always come from the front bank.
- A CPU-requested bank swap is deferred to the next frame boundary.
- Sits between the QSys PIO exports, the LED tile scan driver and the display RAM, all on sys_clk.

Parameters:
- ADDR_W, 11, bank-local address width (pio_addr and scan_addr width).
- DATA_W, 24, pixel width (RGB888).
- MAX_WAIT, 8, maximum cycles a pending CPU write may lose to the scan reader before it is forced in.

Ports:
- clk_clk  in  1  system clock (sys_clk domain).
- reset_reset_n  in  1  asynchronous active-low reset.
- pio_addr  in  ADDR_W  display_buffer_addr_export.
- pio_data  in  DATA_W  display_buffer_data_export.
- pio_ctrl  in  8  display_buffer_ctrl_export:
  - [0] write toggle;
  - [1] swap toggle;
  - [7:2] ignored.
- scan_req  in  1  scan reader read request (level; held until scan_ack).
- scan_addr  in  ADDR_W  scan read address; stable while scan_req is high.
- frame_start  in  1  one-cycle pulse from the scan driver at frame boundary.
- scan_ack  out  1  one-cycle pulse: request accepted.
- scan_valid  out  1  one-cycle pulse: scan_data valid.
- scan_data  out  DATA_W  read data.
- ram_addr  out  ADDR_W+1  {bank, addr}; registered.
- ram_we  out  1  registered write enable.
- ram_wdata  out  DATA_W  registered write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the read address cycle.
- front_bank  out  1  bank currently scanned.
- wr_pending  out  1  CPU write latched, not yet committed.
- swap_pending  out  1  swap requested, not yet performed.
- overflow  out  1  sticky: a CPU write was lost; cleared only by reset.

Behaviour:
- Reset: all outputs 0 (front_bank=0, ram_we=0, ram_addr=0, scan_data=0), internal state cleared, primed=0.
- Toggle detection:
  - The first cycle after reset release (primed=0) loads prev_ctrl[1:0] <= pio_ctrl[1:0], sets primed, and generates no events.
  - Thereafter, any change of pio_ctrl[0] is one write event; any change of pio_ctrl[1] is one swap event.
- Write event: latches {pio_addr, pio_data} into a 1-entry holding register and sets wr_pending.
  - If wr_pending is already set and not committing this same cycle: the new write is dropped, the old one is kept, overflow is set.
  - Write event in the same cycle as a commit: the new write is accepted.
- Swap event: sets swap_pending. A second swap event while pending is absorbed (no double swap).
- Arbitration (evaluated every cycle; one RAM access per cycle):
  - Forced write: wr_pending and wait_cnt==MAX_WAIT -> CPU write.
  - Else scan_req -> scan read.
  - Else wr_pending -> CPU write.
  - Else idle: ram_we=0, ram_addr holds.
  - wait_cnt increments when wr_pending and the write loses; it clears on commit.
- CPU write grant: next cycle ram_we=1, ram_addr={~front_bank, held_addr}, ram_wdata=held_data; wr_pending clears the same edge.
- Scan grant at cycle N:
  - scan_ack=1 in cycle N+1, with ram_addr={front_bank, scan_addr}, ram_we=0.
  - scan_valid=1 and scan_data=ram_rdata in cycle N+2.
  - The requester may drop or change scan_req/scan_addr after seeing scan_ack; back-to-back reads give 1 read per cycle.
- Swap execution:
  - On frame_start with swap_pending=1 and wr_pending=0: front_bank toggles and swap_pending clears on that edge.
  - On frame_start with wr_pending=1: the swap defers to the next frame_start, so the last write lands in the old back bank.
- A read already in flight completes from the bank latched at its grant, even if a swap occurs between grant and data.
- Swap event and frame_start in the same cycle: the swap happens on the following frame_start.
- Mid-operation reset clears everything, including an in-flight read (no scan_valid) and any pending write. overflow clears only here.

Test Plan:
- Reset with pio_ctrl=8'h03, release, hold 5 cycles -> no write and no swap; wr_pending=0, front_bank=0.
- scan_req low; toggle ctrl[0] with addr=0x005, data=0xFF8000 -> 2 cycles later ram_we=1, ram_addr=0x805, ram_wdata=0xFF8000.
- Continuous scan_req for 20 cycles plus one write (MAX_WAIT=8) -> write forced on the 9th losing cycle; exactly one scan_ack gap; no reads lost.
- Two write toggles 1 cycle apart while scan_req is held -> first write committed, overflow=1, second write never reaches RAM.
- Swap toggle, then frame_start -> front_bank=1 next cycle. Swap toggle with wr_pending=1 at frame_start -> front_bank unchanged; flips at the following frame_start.
- Scan read addr 0x010, RAM preloaded bank0[0x010]=0x123456 -> scan_ack at N+1, scan_valid with 0x123456 at N+2; a swap at N+1 does not alter that data.
